dvi_pixel_fifo: RTL
===================

# dvi_pixel_fifo

Pixel buffer stage that sits directly downstream of the DVI/HDMI timing generator in the hdmi_out pcore. It takes 24-bit RGB pixels from the upstream frame-read DMA through a valid/ready FIFO. It pops one pixel per cycle whenever the timing generator's video-enable is high, and outputs registered RGB with data-enable and syncs aligned to it for the DVI encoder. It also requests each new frame from the DMA and detects and recovers from FIFO underflow.

## Interface
- DATA_W, 24, pixel width (8:8:8 RGB)
- ADDR_W, 10, FIFO address width; depth = 2^ADDR_W
- SYNC_POL, 1, active level of hsync_in/vsync_in (1 = active-high)
- clock  in  1  pixel clock; the single clock domain
- reset_n  in  1  asynchronous, active-low reset
- pix_data_in  in  DATA_W  pixel from DMA
- pix_valid_in  in  1  pix_data_in valid
- pix_ready_out  out  1  FIFO accepts/consumes a word this cycle
- frame_req  out  1  one-cycle pulse: DMA must start delivering the next frame from pixel 0
- ve_in, hsync_in, vsync_in  in  1 each  from timing generator
- rgb_out  out  DATA_W  pixel to encoder
- de_out, hsync_out, vsync_out  out  1 each  ve/syncs delayed to align with rgb_out
- underflow  out  1  sticky; set on the first underflow, cleared only by reset
- underflow_cnt  out  8  saturating count of underflowed frames
- fill_level  out  ADDR_W+1  current FIFO occupancy

## Operation
- FIFO: memory of 2^ADDR_W words with ADDR_W+1-bit read/write pointers.
  - Push when pix_valid_in && pix_ready_out in state STREAM.
  - Pop when ve_in && state==STREAM && !empty.
  - Simultaneous push and pop leaves fill_level unchanged.
- Vsync edge detection: vs_edge = (vsync_in==SYNC_POL) && (vs_q!=SYNC_POL). vs_q is registered vsync_in and resets to !SYNC_POL.
- States:
  - SYNC (reset state):
    - pix_ready_out=0.
    - rgb_out=0; de/syncs still pass through.
    - On vs_edge: flush, pulse frame_req, go to STREAM.
  - STREAM:
    - pix_ready_out = !full.
    - ve_in && !empty: pop; rgb_out = head word.
    - ve_in && empty: underflow event. rgb_out=0, set underflow, increment underflow_cnt (saturate at 255), go to RECOVER.
    - vs_edge: flush, pulse frame_req, stay in STREAM. Leftover words from an overlong frame are discarded.
  - RECOVER:
    - pix_ready_out=1; every offered word is accepted and dropped, so the DMA drains.
    - rgb_out=0.
    - underflow_cnt increments only once per frame.
    - On vs_edge: flush, pulse frame_req, go to STREAM.
- Flush: both pointers reset to 0 on the same cycle. A push on the flush cycle is dropped; pix_ready_out is 0 on that cycle.
- vs_edge has priority over pop, push and underflow on the same cycle. ve_in is normally low there.

## Timing
- rgb_out, de_out, hsync_out and vsync_out are registered and lag their inputs by exactly 1 cycle.
- rgb_out is taken from the FIFO head combinationally (fall-through) at pop time.
- rgb_out is 0 whenever de_out=0.
- frame_req is registered: it is high on the cycle after the vs_edge input cycle, for exactly one cycle.
- fill_level is registered and updates the cycle after a push or pop.
- Reset (async assert, sync deassert) drives to 0: rgb_out, de_out, hsync_out, vsync_out, frame_req, pix_ready_out, underflow, underflow_cnt, fill_level and both pointers. State becomes SYNC.
- Reset mid-frame aborts immediately and loses FIFO contents. Output is black until the first vs_edge after release.
- Full (fill_level==2^ADDR_W): pix_ready_out=0 combinationally.
- Pointer wrap is modular; full/empty are decided by MSB compare.

## Test plan
- Reset: hold reset_n=0 while driving inputs.
  - Required: all outputs 0.
  - After release with vsync_in low: pix_ready_out stays 0 and rgb_out=0 while ve_in toggles.
- Frame start: vsync_in rises.
  - Required: frame_req=1 for exactly the next cycle only.
  - Required: pix_ready_out=1 from the cycle after the edge.
- Stream: push 0x000001..0x000008, then ve_in high for 8 cycles.
  - Required: rgb_out=0x000001..0x000008 with de_out=1, each 1 cycle after ve_in.
  - Required: fill_level ends at 0.
- Underflow: 4 words buffered, ve_in high 6 cycles.
  - Required: rgb_out = 1..4, then 0x000000 twice.
  - Required: underflow=1, underflow_cnt=1.
  - Required: further pushes accepted but fill_level stays 0 until the next vs_edge, then STREAM resumes with cnt still 1.
- Full/concurrency: push 1024 words without ve.
  - Required: pix_ready_out=0 at fill 1024.
  - At fill 512, push and pop on the same cycle: fill_level stays 512 and data order is preserved.
- Mid-frame reset: pulse reset_n low during ve.
  - Required: outputs 0 asynchronously, fill_level=0, state SYNC.
  - Required: underflow and underflow_cnt cleared.

Source files
------------

// File: rtl/dvi_pixel_fifo.sv
// dvi_pixel_fifo: pixel buffer between the frame-read DMA and the DVI encoder.
// Buffers RGB words in a fall-through FIFO, pops one word per active video
// cycle, requests each frame from the DMA on the vsync leading edge, and
// blanks the output and drains the DMA after an underflow until the next frame.
module dvi_pixel_fifo #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 10,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pix_data_in,
  input  logic              pix_valid_in,
  output logic              pix_ready_out,
  output logic              frame_req,
  input  logic              ve_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [DATA_W-1:0] rgb_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              underflow,
  output logic [7:0]        underflow_cnt,
  output logic [ADDR_W:0]   fill_level
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {SYNC, STREAM, RECOVER} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W:0]     r_wptr, r_rptr;
  logic                r_vs_q;

  logic                w_vs_edge, w_empty, w_full;
  logic                w_flush, w_push, w_pop, w_uf;
  logic [DATA_W-1:0]   w_head;

  assign w_vs_edge  = (vsync_in == SYNC_POL) && (r_vs_q != SYNC_POL);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                      (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_head     = r_mem[r_rptr[ADDR_W-1:0]];
  assign fill_level = r_wptr - r_rptr;

  // Next state and per-cycle FIFO controls; a vsync edge overrides everything else
  always_comb begin
    w_state_nxt   = r_state;
    pix_ready_out = 1'b0;
    w_flush       = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_uf          = 1'b0;
    if (w_vs_edge) begin
      w_flush     = 1'b1;
      w_state_nxt = STREAM;
    end else begin
      case (r_state)
        SYNC: ;
        STREAM: begin
          pix_ready_out = !w_full;
          w_push        = pix_valid_in && !w_full;
          if (ve_in) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_uf        = 1'b1;
              w_state_nxt = RECOVER;
            end
          end
        end
        // accept and discard everything so the DMA runs out its frame
        RECOVER: pix_ready_out = 1'b1;
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= SYNC;
    else          r_state <= w_state_nxt;
  end

  // Previous vsync level for leading-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_vs_q <= !SYNC_POL;
    else          r_vs_q <= vsync_in;
  end

  // Read/write pointers; flush clears both together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Pixel storage, no reset needed: contents are only read behind the write pointer
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[ADDR_W-1:0]] <= pix_data_in;
  end

  // Registered video outputs; rgb is black unless a word was popped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out   <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      frame_req <= 1'b0;
    end else begin
      rgb_out   <= w_pop ? w_head : '0;
      de_out    <= ve_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      frame_req <= w_vs_edge;
    end
  end

  // Sticky underflow flag and saturating per-frame underflow count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (w_uf) begin
      underflow <= 1'b1;
      if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule
